// File: rtl/sign_extend_pkg.sv
// Shared widths and registered-path extension modes for the immediate extender.
package sign_extend_pkg;

   localparam int IN_W_DEF  = 16;
   localparam int OUT_W_DEF = 32;

   typedef enum logic [1:0] {
      SEXT   = 2'b00,
      ZEXT   = 2'b01,
      UPPER  = 2'b10,
      BRANCH = 2'b11
   } mode_e;

endpackage

// File: rtl/sign_extend_if.sv
// Immediate extender bus: raw field and mode in, combinational and registered results out.
interface sign_extend_if
   import sign_extend_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
);

   logic [IN_W-1:0]  Instr;
   logic [OUT_W-1:0] Signlmm;
   logic             in_valid;
   logic [1:0]       mode;
   logic [OUT_W-1:0] imm_q;
   logic             imm_valid_q;

   modport master (
      output Instr, in_valid, mode,
      input  Signlmm, imm_q, imm_valid_q
   );

   modport slave (
      input  Instr, in_valid, mode,
      output Signlmm, imm_q, imm_valid_q
   );

endinterface

// File: rtl/sign_extend_core.sv
// Combinational immediate extender: sign, zero, upper-placed or branch-offset form.
// Zero latency; no flow control.
module sign_extend_core
   import sign_extend_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [IN_W-1:0]  instr,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){instr[IN_W-1]}}, instr};

   always_comb begin
      ext = sext;
      case (mode)
         SEXT:    ext = sext;
         ZEXT:    ext = {{(OUT_W-IN_W){1'b0}}, instr};
         UPPER:   ext = {instr, {(OUT_W-IN_W){1'b0}}};
         // Word-aligned branch offset; top two sign copies fall off the end.
         BRANCH:  ext = {sext[OUT_W-3:0], 2'b00};
         default: ext = sext;
      endcase
   end

endmodule

// File: rtl/sign_extend.sv
// Immediate extender: Signlmm is combinational sign extension; imm_q is the mode-selected
// value registered one cycle after a valid input. Accepts every cycle, no backpressure.
module sign_extend
   import sign_extend_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   sign_extend_if.slave bus
);

   generate
      if (OUT_W < IN_W + 2) begin : g_width_check
         $error("sign_extend: OUT_W must be at least IN_W + 2");
      end
   endgenerate

   logic [OUT_W-1:0] imm_next;

   sign_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_comb_ext (
      .instr (bus.Instr),
      .mode  (SEXT),
      .ext   (bus.Signlmm)
   );

   sign_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_reg_ext (
      .instr (bus.Instr),
      .mode  (bus.mode),
      .ext   (imm_next)
   );

   // imm_q only loads on valid, so mode is never looked at while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.imm_q       <= '0;
         bus.imm_valid_q <= 1'b0;
      end else begin
         bus.imm_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            bus.imm_q <= imm_next;
         end
      end
   end

endmodule

// File: tb/tb_sign_extend.sv
// Directed-table and random checks of the combinational and registered extension paths.
module tb_sign_extend;
   import sign_extend_pkg::*;

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   sign_extend_if #(.IN_W(16), .OUT_W(32)) bus ();

   sign_extend #(.IN_W(16), .OUT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 if (clk_run) clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [1:0]  mode;
      logic [31:0] exp_comb;
      logic [31:0] exp_reg;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] m);
      logic signed [31:0] s;
      s = $signed(i);
      case (m)
         2'd0:    return s;
         2'd1:    return {16'h0000, i};
         2'd2:    return {i, 16'h0000};
         default: return s * 4;
      endcase
   endfunction

   initial begin
      vecs[0]  = '{16'h8000, SEXT,   32'hFFFF8000, 32'hFFFF8000};
      vecs[1]  = '{16'h8000, ZEXT,   32'hFFFF8000, 32'h00008000};
      vecs[2]  = '{16'h8000, UPPER,  32'hFFFF8000, 32'h80000000};
      vecs[3]  = '{16'h8000, BRANCH, 32'hFFFF8000, 32'hFFFE0000};
      vecs[4]  = '{16'h7FFF, SEXT,   32'h00007FFF, 32'h00007FFF};
      vecs[5]  = '{16'h7FFF, ZEXT,   32'h00007FFF, 32'h00007FFF};
      vecs[6]  = '{16'h7FFF, UPPER,  32'h00007FFF, 32'h7FFF0000};
      vecs[7]  = '{16'h7FFF, BRANCH, 32'h00007FFF, 32'h0001FFFC};
      vecs[8]  = '{16'h0004, SEXT,   32'h00000004, 32'h00000004};
      vecs[9]  = '{16'hFFFF, ZEXT,   32'hFFFFFFFF, 32'h0000FFFF};
      vecs[10] = '{16'hFFFF, BRANCH, 32'hFFFFFFFF, 32'hFFFFFFFC};
      vecs[11] = '{16'h1234, UPPER,  32'h00001234, 32'h12340000};

      bus.Instr    = 16'h0000;
      bus.in_valid = 1'b0;
      bus.mode     = SEXT;
      rst_n        = 1'b0;
      #1;
      check("reset_imm_q", bus.imm_q, 32'h0);
      check("reset_imm_valid_q", {31'h0, bus.imm_valid_q}, 32'h0);

      // Combinational path with clock idle and reset held low.
      for (int i = 0; i < 4; i++) begin
         bus.Instr = vecs[(i < 2) ? (i * 4) : (i + 6)].instr;
         #1;
         check("comb_idle", bus.Signlmm, vecs[(i < 2) ? (i * 4) : (i + 6)].exp_comb);
      end

      clk_run = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back table: a new valid input every cycle.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.Instr    = vecs[i].instr;
         bus.mode     = vecs[i].mode;
         bus.in_valid = 1'b1;
         #1;
         check("table_comb", bus.Signlmm, vecs[i].exp_comb);
         @(posedge clk);
         #1;
         check("table_imm_q", bus.imm_q, vecs[i].exp_reg);
         check("table_valid", {31'h0, bus.imm_valid_q}, 32'h1);
      end

      // Hold: one valid then three idle cycles with changing mode.
      @(negedge clk);
      bus.Instr = 16'h1234;
      bus.mode  = SEXT;
      @(posedge clk);
      #1;
      check("hold_capture", bus.imm_q, 32'h00001234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.mode     = 2'(i + 1);
         bus.Instr    = 16'hABCD;
         @(posedge clk);
         #1;
         check("hold_imm_q", bus.imm_q, 32'h00001234);
         check("hold_valid", {31'h0, bus.imm_valid_q}, 32'h0);
      end

      // Async reset pulse between edges.
      @(negedge clk);
      bus.Instr    = 16'hFFFF;
      bus.mode     = SEXT;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("pulse_pre", bus.imm_q, 32'hFFFFFFFF);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("pulse_imm_q", bus.imm_q, 32'h0);
      check("pulse_valid", {31'h0, bus.imm_valid_q}, 32'h0);
      check("pulse_comb", bus.Signlmm, 32'hFFFFFFFF);
      bus.Instr = 16'h0004;
      #1;
      check("reset_comb_tracks", bus.Signlmm, 32'h00000004);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_pulse_imm_q", bus.imm_q, 32'h0);

      // Reset asserted just before a capturing edge discards that capture.
      @(negedge clk);
      bus.Instr    = 16'h7FFF;
      bus.mode     = UPPER;
      bus.in_valid = 1'b1;
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_imm_q", bus.imm_q, 32'h0);
      check("mid_reset_valid", {31'h0, bus.imm_valid_q}, 32'h0);
      check("mid_reset_comb", bus.Signlmm, 32'h00007FFF);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_capture", bus.imm_q, 32'h7FFF0000);
      check("first_capture_valid", {31'h0, bus.imm_valid_q}, 32'h1);

      // Random stream against the reference model.
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] exp_v;
         @(negedge clk);
         bus.Instr    = 16'($urandom);
         bus.mode     = 2'($urandom_range(3));
         bus.in_valid = 1'b1;
         exp_v = model(bus.Instr, bus.mode);
         #1;
         check("rand_comb", bus.Signlmm, model(bus.Instr, 2'd0));
         @(posedge clk);
         #1;
         check("rand_imm_q", bus.imm_q, exp_v);
         check("rand_valid", {31'h0, bus.imm_valid_q}, 32'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
